// File: rtl/vend_controller.sv
// Vending sequencer: accumulates coin credit, checks it against the selected
// item price, pulses dispense and returns change through a valid/ack handshake.
// Every output comes straight from a register, so each response shows up in
// the cycle after the edge that sampled the strobe.
module vend_controller #(
    parameter logic [3:0] PRICE0  = 4'd10,
    parameter logic [3:0] PRICE1  = 4'd7,
    parameter logic [3:0] PRICE2  = 4'd12,
    parameter logic [3:0] PRICE3  = 4'd15,
    parameter int         TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic       change_ack,
    output logic [4:0] paid,
    output logic       busy,
    output logic       dispense,
    output logic [1:0] item_out,
    output logic       insufficient,
    output logic       coin_reject,
    output logic       change_valid,
    output logic [4:0] change_amt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    // Wide enough to hold TIMEOUT-1, the last idle count before refunding.
    localparam int CW = $clog2(TIMEOUT + 1);

    // Packed lookup tables, unpacked below into per-index entries.
    localparam logic [15:0] PRICE_TABLE = {PRICE3, PRICE2, PRICE1, PRICE0};
    localparam logic [19:0] COIN_TABLE  = {5'd10, 5'd5, 5'd2, 5'd1};

    logic [3:0] price_tbl [4];
    logic [4:0] coin_tbl  [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_tables
            assign price_tbl[gi] = PRICE_TABLE[gi*4 +: 4];
            assign coin_tbl[gi]  = COIN_TABLE[gi*5 +: 5];
        end
    endgenerate

    state_t        state_reg, state_next;
    logic [4:0]    paid_reg, paid_next;
    logic [CW-1:0] idle_cnt_reg, idle_cnt_next;
    logic [3:0]    price_reg, price_next;
    logic          busy_reg, busy_next;
    logic          dispense_reg, dispense_next;
    logic [1:0]    item_reg, item_next;
    logic          insufficient_reg, insufficient_next;
    logic          coin_reject_reg, coin_reject_next;
    logic          change_valid_reg, change_valid_next;
    logic [4:0]    change_amt_reg, change_amt_next;

    logic [4:0] coin_value;
    logic [5:0] coin_sum;
    logic [4:0] sel_price;
    logic       sel_ok;
    logic       any_strobe;
    logic       timeout_hit;
    logic [4:0] dispense_change;

    // Datapath helpers shared by the next-state logic.
    assign coin_value      = coin_tbl[coin_type];
    // Six bits so a sum above 31 is detected instead of wrapping.
    assign coin_sum        = {1'b0, paid_reg} + {1'b0, coin_value};
    assign sel_price       = {1'b0, price_tbl[sel]};
    assign sel_ok          = (paid_reg >= sel_price);
    assign any_strobe      = coin_valid | sel_valid | cancel;
    // The idle cycle that would bring the count to TIMEOUT triggers the refund.
    assign timeout_hit     = (idle_cnt_reg == CW'(TIMEOUT - 1)) && !any_strobe;
    // Only evaluated in DISPENSE, where paid_reg >= price_reg always holds.
    assign dispense_change = paid_reg - {1'b0, price_reg};

    // Next-state and next-output logic for all four states.
    always_comb begin
        state_next        = state_reg;
        paid_next         = paid_reg;
        idle_cnt_next     = idle_cnt_reg;
        price_next        = price_reg;
        dispense_next     = 1'b0;
        item_next         = 2'd0;
        insufficient_next = 1'b0;
        coin_reject_next  = 1'b0;
        change_valid_next = change_valid_reg;
        change_amt_next   = change_amt_reg;

        unique case (state_reg)
            IDLE: begin
                idle_cnt_next = '0;
                if (coin_valid) begin
                    // A single coin can never exceed 31, so it is always taken.
                    paid_next  = coin_value;
                    state_next = COLLECT;
                end
                if (sel_valid) begin
                    insufficient_next = 1'b1;
                end
            end

            COLLECT: begin
                if (cancel) begin
                    // A coin offered alongside cancel is not credited.
                    coin_reject_next  = coin_valid;
                    change_amt_next   = paid_reg;
                    change_valid_next = 1'b1;
                    paid_next         = 5'd0;
                    idle_cnt_next     = '0;
                    state_next        = CHANGE;
                end else if (sel_valid) begin
                    coin_reject_next = coin_valid;
                    idle_cnt_next    = '0;
                    if (sel_ok) begin
                        price_next    = price_tbl[sel];
                        dispense_next = 1'b1;
                        item_next     = sel;
                        state_next    = DISPENSE;
                    end else begin
                        insufficient_next = 1'b1;
                    end
                end else if (coin_valid) begin
                    idle_cnt_next = '0;
                    if (coin_sum[5]) begin
                        coin_reject_next = 1'b1;
                    end else begin
                        paid_next = coin_sum[4:0];
                    end
                end else if (timeout_hit) begin
                    change_amt_next   = paid_reg;
                    change_valid_next = 1'b1;
                    paid_next         = 5'd0;
                    idle_cnt_next     = '0;
                    state_next        = CHANGE;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
            end

            DISPENSE: begin
                coin_reject_next = coin_valid;
                change_amt_next  = dispense_change;
                paid_next        = 5'd0;
                if (dispense_change != 5'd0) begin
                    change_valid_next = 1'b1;
                    state_next        = CHANGE;
                end else begin
                    change_valid_next = 1'b0;
                    state_next        = IDLE;
                end
            end

            CHANGE: begin
                coin_reject_next = coin_valid;
                if (change_ack) begin
                    change_valid_next = 1'b0;
                    change_amt_next   = 5'd0;
                    state_next        = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == DISPENSE) || (state_next == CHANGE);
    end

    // State and output registers; reset discards any credit outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            paid_reg         <= 5'd0;
            idle_cnt_reg     <= '0;
            price_reg        <= 4'd0;
            busy_reg         <= 1'b0;
            dispense_reg     <= 1'b0;
            item_reg         <= 2'd0;
            insufficient_reg <= 1'b0;
            coin_reject_reg  <= 1'b0;
            change_valid_reg <= 1'b0;
            change_amt_reg   <= 5'd0;
        end else begin
            state_reg        <= state_next;
            paid_reg         <= paid_next;
            idle_cnt_reg     <= idle_cnt_next;
            price_reg        <= price_next;
            busy_reg         <= busy_next;
            dispense_reg     <= dispense_next;
            item_reg         <= item_next;
            insufficient_reg <= insufficient_next;
            coin_reject_reg  <= coin_reject_next;
            change_valid_reg <= change_valid_next;
            change_amt_reg   <= change_amt_next;
        end
    end

    assign paid         = paid_reg;
    assign busy         = busy_reg;
    assign dispense     = dispense_reg;
    assign item_out     = item_reg;
    assign insufficient = insufficient_reg;
    assign coin_reject  = coin_reject_reg;
    assign change_valid = change_valid_reg;
    assign change_amt   = change_amt_reg;

endmodule
